// File: rtl/lsu_mem_stage.sv
// Load/store unit for the MEM stage, sitting in front of a word-addressed data memory.
// Latency: load and word store respond 2 cycles after accept, sub-word store 3 cycles.
// Backpressure: req_ready is high only in IDLE; the response is a pulse with no stall.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_*               request from EX (valid/ready), byte address, store data
//   resp_*              one-cycle completion pulse with extended load data / exception
//   busy                unit is between accept and response
//   mem_*, MemRead/Write word-indexed memory interface (read data arrives one cycle
//                       after MemRead)
//
// Optional feature: define LSU_MISALIGN_EXC_EN to flag misaligned half/word accesses
// through resp_exc instead of silently ignoring the misaligned low address bits.

module lsu_mem_stage #(
    parameter int WORD_IDX_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writedata,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] mem_readdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;

    // Latched request. Only the address bits that select a word index and a lane
    // are kept; higher bits wrap away by construction.
    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [WORD_IDX_W+1:0]   r_addr;
    logic [31:0]             r_wdata;

    logic                    w_accept;
    logic                    w_req_word;
    logic                    w_req_misalign;
    logic                    w_is_word;
    logic [31:0]             w_merge;
    logic [31:0]             w_load_data;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic                    w_resp_exc;

    // Address bits above the word index are intentionally ignored.
    logic                    w_unused_addr;
    assign w_unused_addr = &{1'b0, req_addr[31:WORD_IDX_W+2]};

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_req_word = req_size[1];   // 10 and 11 are both word accesses
    assign w_is_word  = r_size[1];

`ifdef LSU_MISALIGN_EXC_EN
    logic r_exc;

    assign w_req_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                            (w_req_word && (req_addr[1:0] != 2'b00));
    assign w_resp_exc     = r_exc;
`else
    assign w_req_misalign = 1'b0;
    assign w_resp_exc     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_misalign)
                        w_state_nxt = S_DONE;
                    else if (!req_we)
                        w_state_nxt = S_RD;
                    else if (w_req_word)
                        w_state_nxt = S_WR;
                    else
                        w_state_nxt = S_RD;   // sub-word store: read first, then merge
                end
            end
            S_RD:    w_state_nxt = r_we ? S_WR : S_DONE;
            S_WR:    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr[WORD_IDX_W+1:0];
                r_wdata    <= req_wdata;
            end
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_exc <= 1'b0;
        else if (w_accept)
            r_exc <= w_req_misalign;
    end
`endif

    // ------------------------------------------------------------------
    // Sub-word store merge: the word read in RD arrives on mem_readdata
    // during WR, and only the target lane is replaced.
    // ------------------------------------------------------------------
    always_comb begin
        w_merge = mem_readdata;
        if (r_size == SZ_BYTE) begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else begin
            if (r_addr[1])
                w_merge[31:16] = r_wdata[15:0];
            else
                w_merge[15:0]  = r_wdata[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Load lane select and extension
    // ------------------------------------------------------------------
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_readdata[7:0];
            2'd1:    w_byte = mem_readdata[15:8];
            2'd2:    w_byte = mem_readdata[23:16];
            default: w_byte = mem_readdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_readdata[31:16] : mem_readdata[15:0];

        if (w_is_word)
            w_load_data = mem_readdata;
        else if (r_size == SZ_HALF)
            w_load_data = {{16{w_half[15] & ~r_unsigned}}, w_half};
        else
            w_load_data = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
    end

    // ------------------------------------------------------------------
    // Outputs. Memory strobes decode straight from the state register so an
    // asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    assign MemRead  = (r_state == S_RD);
    assign MemWrite = (r_state == S_WR);

    // The index stays valid through RD and WR so the merged word lands where it was read.
    assign mem_addr = busy ? {{(32-WORD_IDX_W){1'b0}}, r_addr[WORD_IDX_W+1:2]} : 32'd0;

    assign mem_writedata = (r_state == S_WR) ? (w_is_word ? r_wdata : w_merge) : 32'd0;

    assign resp_valid = (r_state == S_DONE);
    assign resp_exc   = resp_valid && w_resp_exc;
    assign resp_rdata = (resp_valid && !r_we && !w_resp_exc) ? w_load_data : 32'd0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a behavioural 256x32 registered-read memory.
// Latency: not applicable.
// Backpressure: not applicable.

module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_readdata;

    int n_cmp = 0;
    int n_err = 0;

    lsu_mem_stage #(.WORD_IDX_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_exc     (resp_exc),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_writedata(mem_writedata),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_readdata (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: mem[i] = i after load, registered read, synchronous write.
    logic [31:0] mem [256];
    logic        mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= i;
            mem_readdata <= 32'd0;
        end else begin
            if (MemWrite) mem[mem_addr[7:0]] <= mem_writedata;
            if (MemRead)  mem_readdata <= mem[mem_addr[7:0]];
        end
    end

    // Per-transaction observations (bit c of a mask = activity in cycle c after accept)
    logic [7:0]  rd_mask, wr_mask;
    logic [31:0] rd_addr, wr_addr, wr_data, r_data;
    logic        r_exc;
    int          resp_cyc, resp_cnt, both_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        rd_mask = 0; wr_mask = 0; rd_addr = 'x; wr_addr = 'x; wr_data = 'x;
        r_data = 'x; r_exc = 1'bx; resp_cyc = 0; resp_cnt = 0;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (MemRead)  begin rd_mask[c] = 1'b1; rd_addr = mem_addr; end
            if (MemWrite) begin wr_mask[c] = 1'b1; wr_addr = mem_addr; wr_data = mem_writedata; end
            if (MemRead && MemWrite) both_cnt++;
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cyc == 0) begin resp_cyc = c; r_data = resp_rdata; r_exc = resp_exc; end
            end
        end
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, sz, uns, addr, 32'd0);
        chk({tag, "_rdmask"}, {24'd0, rd_mask}, 32'h02);
        chk({tag, "_wrmask"}, {24'd0, wr_mask}, 32'h00);
        chk({tag, "_respcyc"}, resp_cyc, 32'd2);
        chk({tag, "_data"}, r_data, exp);
        chk({tag, "_exc"}, {31'd0, r_exc}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_w, cnt_r;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; both_cnt = 0;
        reset = 1'b1; mem_load = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        // Reset state
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_memrw", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("rst_resp", {30'd0, resp_valid, resp_exc}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_writedata, 32'd0);
        reset = 1'b0; mem_load = 1'b0;

        // LW 0x14 -> mem[5]
        do_load("lw14", 2'b10, 1'b0, 32'h14, 32'h0000_0005);
        chk("lw14_addr", rd_addr, 32'd5);

        // SB 0xAB at 0x0D -> mem[3] = 0x0000AB03
        issue(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00AB);
        chk("sb_rdmask", {24'd0, rd_mask}, 32'h02);
        chk("sb_wrmask", {24'd0, wr_mask}, 32'h04);
        chk("sb_respcyc", resp_cyc, 32'd3);
        chk("sb_respcnt", resp_cnt, 32'd1);
        chk("sb_addr", rd_addr, 32'd3);
        chk("sb_waddr", wr_addr, 32'd3);
        chk("sb_wdata", wr_data, 32'h0000_AB03);
        chk("sb_rdata0", r_data, 32'd0);
        do_load("lb0d", 2'b00, 1'b0, 32'h0D, 32'hFFFF_FFAB);
        do_load("lbu0d", 2'b00, 1'b1, 32'h0D, 32'h0000_00AB);

        // SH 0x8001 at 0x12 -> mem[4] = 0x80010004
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
        chk("sh_wrmask", {24'd0, wr_mask}, 32'h04);
        chk("sh_wdata", wr_data, 32'h8001_0004);
        chk("sh_respcyc", resp_cyc, 32'd3);
        chk("sh_mem4", mem[4], 32'h8001_0004);
        do_load("lh12", 2'b01, 1'b0, 32'h12, 32'hFFFF_8001);
        do_load("lhu10", 2'b01, 1'b1, 32'h10, 32'h0000_0004);
        do_load("lb13", 2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
        do_load("lbu12", 2'b00, 1'b1, 32'h12, 32'h0000_0001);
        do_load("lh10s", 2'b01, 1'b0, 32'h10, 32'h0000_0004);

        // SW 0xDEADBEEF at 0x400 wraps to index 0; no read phase
        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEAD_BEEF);
        chk("sw_rdmask", {24'd0, rd_mask}, 32'h00);
        chk("sw_wrmask", {24'd0, wr_mask}, 32'h02);
        chk("sw_respcyc", resp_cyc, 32'd2);
        chk("sw_waddr", wr_addr, 32'd0);
        chk("sw_wdata", wr_data, 32'hDEAD_BEEF);
        do_load("lw00", 2'b10, 1'b1, 32'h0, 32'hDEAD_BEEF);
        do_load("lw11sz", 2'b11, 1'b0, 32'h0, 32'hDEAD_BEEF);

        // Misaligned LW 0x15
        issue(1'b0, 2'b10, 1'b0, 32'h15, 32'd0);
`ifdef LSU_MISALIGN_EXC_EN
        chk("mis_rdmask", {24'd0, rd_mask}, 32'h00);
        chk("mis_respcyc", resp_cyc, 32'd1);
        chk("mis_exc", {31'd0, r_exc}, 32'd1);
        chk("mis_data", r_data, 32'd0);
`else
        chk("mis_rdmask", {24'd0, rd_mask}, 32'h02);
        chk("mis_respcyc", resp_cyc, 32'd2);
        chk("mis_exc", {31'd0, r_exc}, 32'd0);
        chk("mis_data", r_data, 32'h0000_0005);
`endif

        // SB to 0x0C with reset pulsed during RD
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0C; req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_rd", {31'd0, MemRead}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_rddrop", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt_w = 0; cnt_r = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (MemWrite) cnt_w++;
            if (resp_valid) cnt_r++;
        end
        chk("rstmid_nowrite", cnt_w, 32'd0);
        chk("rstmid_noresp", cnt_r, 32'd0);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_mem3", mem[3], 32'h0000_AB03);
        do_load("lw0c", 2'b10, 1'b0, 32'h0C, 32'h0000_AB03);

        chk("never_rd_wr_together", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
